// File: rtl/slave_fifo.sv
// rtl/slave_fifo.sv - valid/ready receive stage with first-word-fall-through FIFO
// Backpressure comes only from registered occupancy; no consumer-to-ready path.
module slave_fifo #(
   parameter int L     = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid,
   output logic          ready,
   input  logic [L-1:0]  data_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [L-1:0]  data_out,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [L-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_next;
   logic          push;
   logic          pop;

   assign out_valid = (count != '0);
   assign push      = valid & ready;
   assign pop       = out_valid & out_ready;
   assign data_out  = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // ready looks at next occupancy so a push reaching full drops it on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_next;
         ready <= (count_next < FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_slave_fifo.sv
// tb/tb_slave_fifo.sv - self-checking bench for slave_fifo
// Vector table, directed sequences and a queue-based random scoreboard.
module tb_slave_fifo;

   logic       clk;
   logic       rst;
   logic       valid;
   logic       ready;
   logic [7:0] data_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] data_out;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   slave_fifo #(.L(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .ready     (ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       ordy;
      logic [7:0] d;
      logic       e_rdy;
      logic [2:0] e_cnt;
      logic       e_ov;
      logic [7:0] e_dout;
      logic       chk_d;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q [$];
   logic       m_ready;
   logic       m_push;
   logic       m_pop;

   initial begin
      rst       = 1'b0;
      valid     = 1'b1;
      data_in   = 8'h11;
      out_ready = 1'b0;

      // reset and release
      #2;
      check("rst_ready", ready, 0);
      check("rst_count", count, 0);
      check("rst_ov", out_valid, 0);
      step();
      step();
      rst = 1'b1;
      check("release_ready", ready, 0);
      step();
      check("first_edge_ready", ready, 1);
      check("first_edge_count", count, 0);
      step();
      check("cap11_count", count, 1);
      check("cap11_ov", out_valid, 1);
      check("cap11_dout", data_out, 8'h11);
      valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("pop11_count", count, 0);
      check("pop11_ov", out_valid, 0);
      out_ready = 1'b0;

      // fill to full, hold a fifth word, drain
      tbl[0] = '{1'b1, 1'b0, 8'hA1, 1'b1, 3'd1, 1'b1, 8'hA1, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 8'hA2, 1'b1, 3'd2, 1'b1, 8'hA1, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 8'hA3, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 8'hA4, 1'b0, 3'd4, 1'b1, 8'hA1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 8'hA5, 1'b0, 3'd4, 1'b1, 8'hA1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 8'hA5, 1'b1, 3'd3, 1'b1, 8'hA2, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 8'hA5, 1'b1, 3'd3, 1'b1, 8'hA3, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd2, 1'b1, 8'hA4, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b1};
      tbl[9] = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
      for (int i = 0; i < 10; i++) begin
         valid     = tbl[i].v;
         out_ready = tbl[i].ordy;
         data_in   = tbl[i].d;
         step();
         check($sformatf("vec%0d_ready", i), ready, tbl[i].e_rdy);
         check($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
         check($sformatf("vec%0d_ov", i), out_valid, tbl[i].e_ov);
         if (tbl[i].chk_d) check($sformatf("vec%0d_dout", i), data_out, tbl[i].e_dout);
      end

      // streaming 16 words, pointers wrap four times
      valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'(i);
         step();
         check($sformatf("stream%0d_count", i), count, 1);
         check($sformatf("stream%0d_dout", i), data_out, i);
      end
      valid = 1'b0;
      step();
      check("stream_end_count", count, 0);
      check("stream_end_ov", out_valid, 0);

      // random traffic against a queue model
      m_ready = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         valid     = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 1) == 1);
         data_in   = 8'($urandom_range(0, 255));
         #1;
         check("rnd_ready", ready, m_ready);
         check("rnd_count", count, q.size());
         check("rnd_ov", out_valid, q.size() != 0);
         if (q.size() != 0) check("rnd_dout", data_out, q[0]);
         if (count > 3'd4) check("rnd_count_max", count, 4);
         m_push = valid & m_ready;
         m_pop  = out_ready & (q.size() != 0);
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(data_in);
         m_ready = (q.size() < 4);
         step();
      end

      // drain, load three words, reset mid-operation
      valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
      check("pre_rst_count", count, 0);
      out_ready = 1'b0;
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'hC0 + 8'(i);
         step();
      end
      valid = 1'b0;
      check("pre_rst_fill", count, 3);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_count", count, 0);
      check("midrst_ov", out_valid, 0);
      check("midrst_ready", ready, 0);
      step();
      rst = 1'b1;
      check("midrel_ready", ready, 0);
      out_ready = 1'b1;
      step();
      check("after_rel_ready", ready, 1);
      check("after_rel_count", count, 0);
      check("after_rel_ov", out_valid, 0);
      step();
      check("stale_ov", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/slave_fifo.md
# slave_fifo

Downstream receive stage for the valid/ready master stage. It accepts words on a valid/ready handshake, buffers them in a small first-word-fall-through FIFO, and presents them to the next consumer on a second valid/ready interface. Backpressure is generated from FIFO occupancy only, with no combinational path from the consumer side back to `ready`.

## Interface
Parameters:
- `L`, 8, data width in bits.
- `DEPTH`, 4, FIFO depth in words. Must be a power of two and at least 2.
- `AW`, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1, sole clock. All state changes on the rising edge.
- `rst`, input, 1, asynchronous active-low reset.
- `valid`, input, 1, upstream word available.
- `ready`, output, 1, registered. Slave can accept a word this cycle.
- `data_in`, input, L, upstream word, sampled when `valid & ready`.
- `out_valid`, output, 1, FIFO non-empty; `data_out` is meaningful.
- `out_ready`, input, 1, consumer accepts the head word.
- `data_out`, output, L, head-of-FIFO word (fall-through).
- `count`, output, AW+1, current occupancy, 0..DEPTH.

## Operation
- Push: `push = valid & ready`. On the clock edge, `mem[wr_ptr] <= data_in` and `wr_ptr` increments modulo DEPTH.
- Pop: `pop = out_valid & out_ready`. On the clock edge, `rd_ptr` increments modulo DEPTH.
- `count` next value:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- `count` never exceeds DEPTH and never goes below 0 by construction:
  - `ready` is low when full, so no push can occur.
  - `out_valid` is low when empty, so no pop can occur.
- `ready` is a register: `ready <= (count_next < DEPTH)`. It is a function of the next occupancy only and never depends combinationally on `out_ready` or `valid`.
- `out_valid = (count != 0)`, combinational from the `count` register.
- `data_out = mem[rd_ptr]`. When the FIFO is empty, `data_out` holds the last popped or stale storage value. The consumer must ignore it while `out_valid` is 0.
- Pointers wrap naturally at AW bits. Full and empty are distinguished only by `count`.
- Data storage is not reset. Pointers, `count` and `ready` are reset.

## Timing
- Reset values (asserted asynchronously, immediately when `rst` goes low):
  - `ready` = 0, `count` = 0, `out_valid` = 0, `wr_ptr` = 0, `rd_ptr` = 0.
  - `data_out` = value of `mem[0]`; undefined and not checked.
- Reset release: `ready` rises at the first rising edge of `clk` after `rst` goes high. No push is possible in the cycle in which `rst` is released.
- Latency: a word pushed at edge N appears on `data_out` with `out_valid` = 1 immediately after edge N, so it can be popped at edge N+1. This is one-cycle fall-through.
- Throughput: one push and one pop per cycle, sustained, when neither side stalls.
- Full, with `pop` in the same cycle: `ready` is 0, so no push. `count` goes from DEPTH to DEPTH-1, and `ready` is 1 after that edge.
- Reaching full: a push at count DEPTH-1 with no pop makes `count` = DEPTH, and `ready` is 0 after the same edge. No word is ever dropped.
- Empty, `valid` = 1: the push proceeds. `out_valid` rises after the edge and `count` = 1.
- Simultaneous push and pop at 0 < count < DEPTH: `count` is unchanged and both pointers advance.
- Reset mid-operation: the FIFO is emptied instantly and all buffered words are discarded. Upstream must re-send after `ready` returns.
- `count` reaches DEPTH only when `ready` is 0. `ready` is 1 on every cycle with `count` < DEPTH, except the first cycle after reset release.

## Test plan
- Reset, then release with `valid` = 1 and `data_in` = 0x11:
  - `ready` = 0 during reset and in the release cycle, `count` = 0, `out_valid` = 0.
  - `ready` = 1 from the first edge after release.
  - 0x11 is captured at the following edge.
- Fill with `out_ready` = 0, pushing 0xA1, 0xA2, 0xA3, 0xA4 (DEPTH = 4):
  - `count` goes 1, 2, 3, 4.
  - `ready` = 0 after the 4th push.
  - A 5th word 0xA5 held on `data_in` is not captured.
  - `data_out` = 0xA1 throughout.
- Drain from full with `out_ready` = 1:
  - `data_out` sequence is 0xA1, 0xA2, 0xA3, 0xA4.
  - `ready` = 1 after the first pop.
  - 0xA5 is accepted next and emerges after 0xA4.
  - `out_valid` = 0 when `count` = 0.
- Streaming 16 words 0x00..0x0F with `valid` = 1 and `out_ready` = 1:
  - One word transfers per cycle, in order.
  - `count` stays at 1 after the first push.
  - Pointers wrap four times with no loss or duplication.
- Random `valid` and `out_ready` (about 50% each, 1000 cycles) against a scoreboard:
  - Output order equals input order.
  - `count` always equals pushes minus pops.
  - `count` is never above 4.
- Assert `rst` low for one cycle with `count` = 3:
  - `count`, `out_valid` and `ready` drop to 0 immediately.
  - After release, the stale words are not presented.
